// File: rtl/systolic_pkg.sv
// systolic_pkg: element format widths and the feeder state encoding shared by the feeder blocks
package systolic_pkg;
  localparam int D_W_DEF = 16;
  localparam int Q_INT_W = 2;
  localparam int Q_FRAC_W = 13;
  typedef enum logic [1:0] {ST_LOAD, ST_STREAM, ST_DONE} feeder_state_e;
endpackage

// File: rtl/feeder_buf.sv
// feeder_buf: K-entry tile buffer with one vector write port and an independent read port per lane
module feeder_buf import systolic_pkg::*; #(
  parameter int D_W = D_W_DEF,
  parameter int N = 4,
  parameter int K = 8,
  parameter int AW = (K > 1) ? $clog2(K) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [N*D_W-1:0] wdata_i,
  input  logic [N*AW-1:0]  raddr_i,
  output logic [N*D_W-1:0] rdata_o
);
  logic [N*D_W-1:0] mem_q [K];
  always_ff @(posedge clk_i)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  for (genvar g = 0; g < N; g++) begin : g_rd
    assign rdata_o[g*D_W +: D_W] = mem_q[raddr_i[g*AW +: AW]][g*D_W +: D_W];
  end
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: loads a K-vector tile then streams it skewed into N array rows; SYSTOLIC_FEEDER_STALL_CNT_EN adds O_STALL_CNT
module systolic_feeder import systolic_pkg::*; #(
  parameter int D_W = D_W_DEF,
  parameter int N = 4,
  parameter int K = 8
) (
  input  logic             I_CLK,
  input  logic             I_SYNC_RSTN,
  input  logic             I_VLD,
  input  logic [N*D_W-1:0] I_VEC,
  output logic             O_RDY,
  input  logic             I_ACK,
  output logic [N-1:0]     O_VLD,
  output logic [N*D_W-1:0] O_X,
  output logic             O_DONE
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]      O_STALL_CNT
`endif
);
  localparam int AW = (K > 1) ? $clog2(K) : 1;
  localparam int SW = $clog2(K + N);
  localparam logic [AW-1:0] V_LAST = AW'(K - 1);
  localparam logic [SW-1:0] S_LAST = SW'(K + N - 2);
  feeder_state_e state_q, state_d;
  logic [AW-1:0] v_q, v_d;
  logic [SW-1:0] s_q, s_d;
  logic [N-1:0] vld_q, vld_d;
  logic [N*D_W-1:0] x_q, x_d, rd_data;
  logic [N*AW-1:0] rd_addr;
  logic xfer;
  assign O_RDY = state_q == ST_LOAD;
  assign O_DONE = state_q == ST_DONE;
  assign O_VLD = vld_q;
  assign O_X = x_q;
  assign xfer = O_RDY & I_VLD;
  always_comb begin
    state_d = state_q;
    v_d = v_q;
    s_d = s_q;
    case (state_q)
      ST_LOAD: if (I_VLD) begin
        v_d = v_q + 1'b1;
        if (v_q == V_LAST) begin
          state_d = ST_STREAM;
          v_d = '0;
          s_d = '0;
        end
      end
      ST_STREAM: if (I_ACK) begin
        s_d = s_q + 1'b1;
        if (s_q == S_LAST) state_d = ST_DONE;
      end
      default: begin
        state_d = ST_LOAD;
        v_d = '0;
        s_d = '0;
      end
    endcase
  end
  // outputs are computed from the next step so the wavefront appears registered with its step
  for (genvar l = 0; l < N; l++) begin : g_lane
    logic [SW:0] d;
    assign d = {1'b0, s_d} - (SW+1)'(l);
    assign vld_d[l] = state_d == ST_STREAM && !d[SW] && d < (SW+1)'(K);
    assign rd_addr[l*AW +: AW] = d[AW-1:0];
    assign x_d[l*D_W +: D_W] = vld_d[l] ? rd_data[l*D_W +: D_W] : '0;
  end
  feeder_buf #(.D_W(D_W), .N(N), .K(K), .AW(AW)) u_buf (
    .clk_i(I_CLK),
    .we_i(xfer),
    .waddr_i(v_q),
    .wdata_i(I_VEC),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );
  always_ff @(posedge I_CLK) begin
    if (!I_SYNC_RSTN) begin
      state_q <= ST_LOAD;
      v_q <= '0;
      s_q <= '0;
      vld_q <= '0;
      x_q <= '0;
    end else begin
      state_q <= state_d;
      v_q <= v_d;
      s_q <= s_d;
      vld_q <= vld_d;
      x_q <= x_d;
    end
  end
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  logic [31:0] stall_q;
  assign O_STALL_CNT = stall_q;
  always_ff @(posedge I_CLK) begin
    if (!I_SYNC_RSTN || state_q == ST_DONE) stall_q <= '0;
    else if (state_q == ST_STREAM && !I_ACK && stall_q != '1) stall_q <= stall_q + 1'b1;
  end
`endif
endmodule
